// File: rtl/map_rom_arbiter.sv
// Shares one synchronous-read map ROM port among NUM_REQ requesters. Each cycle at most one
// request is granted, and its ROM word is steered back ROM_LAT+1 cycles later by a one-hot tag.
module map_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ROM_LAT = 1,
    parameter bit          PRIO0   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic                      stall,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    logic [PtrW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]                win_idx;
    logic [PtrW-1:0]                cand;
    logic                           found;
    logic [ADDR_W-1:0]              sel_addr;
    logic [ROM_LAT:0][NUM_REQ-1:0]  tag_q;

    // Arbitration: optional strict priority for requester 0, otherwise round-robin from rr_ptr.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        if (rst_n && !stall && (|req)) begin
            if (PRIO0 && req[0]) begin
                gnt[0] = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
                    if (!found && req[cand]) begin
                        found     = 1'b1;
                        gnt[cand] = 1'b1;
                        win_idx   = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PtrW'(i)) begin
                sel_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // A priority grant to requester 0 leaves the rotation where it was.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((|gnt) && !(PRIO0 && (win_idx == '0))) begin
            rr_ptr_d = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            rom_addr <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (|gnt) begin
                rom_addr <= sel_addr;
            end
        end
    end

    // Tag pipeline: gnt is all-zero on idle cycles, which doubles as the invalid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= gnt;
            for (int unsigned s = 1; s <= ROM_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s < ROM_LAT; s++) begin
            busy = busy | (|tag_q[s]);
        end
    end

    assign rsp_valid = tag_q[ROM_LAT];
    assign rsp_data  = rom_data;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter: one round-robin instance and one with requester-0 priority,
// both fed by the same stimulus and each backed by its own 1-cycle synchronous ROM model.
module tb_map_rom_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 12;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic            stall;

    logic [N-1:0]  gnt_a, rsp_valid_a, gnt_b, rsp_valid_b;
    logic [AW-1:0] rom_addr_a, rom_addr_b;
    logic [DW-1:0] rom_data_a, rom_data_b, rsp_data_a, rsp_data_b;
    logic          busy_a, busy_b;

    logic [DW-1:0] rom [0:65535];

    int checks = 0;
    int errors = 0;

    map_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .PRIO0(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .stall(stall), .gnt(gnt_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rsp_valid(rsp_valid_a),
        .rsp_data(rsp_data_a), .busy(busy_a)
    );

    map_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .PRIO0(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .stall(stall), .gnt(gnt_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data_a <= rom[rom_addr_a];
        rom_data_b <= rom[rom_addr_b];
    end

    function automatic logic [DW-1:0] romval(input logic [AW-1:0] a);
        if (a == 16'h0102) return 12'hABC;
        return a[11:0] ^ 12'h5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_addr(input int unsigned i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = romval(16'(i));
        rom_data_a = '0;
        rom_data_b = '0;
        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
        stall = 1'b0;

        // Reset state, including gnt forced low while held in reset
        tick();
        req = 4'b1111;
        #1;
        chk("rst_gnt_a", 32'(gnt_a), 32'h0);
        chk("rst_gnt_b", 32'(gnt_b), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr_a), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        req = '0;
        rst_n = 1'b1;
        tick();

        // Single request
        req = 4'b0001;
        set_addr(0, 16'h0102);
        #1;
        chk("single_gnt", 32'(gnt_a), 32'b0001);
        tick();
        req = '0;
        #1;
        chk("single_rom_addr", 32'(rom_addr_a), 32'h0102);
        chk("single_rsp_early", 32'(rsp_valid_a), 32'h0);
        chk("single_busy", 32'(busy_a), 32'h1);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid_a), 32'b0001);
        chk("single_rsp_data", 32'(rsp_data_a), 32'hABC);
        chk("single_busy_done", 32'(busy_a), 32'h0);
        tick();
        chk("single_rsp_once", 32'(rsp_valid_a), 32'h0);

        // All requesters continuous, round-robin
        rst_pulse();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 16'(16'h10 * (i + 1)));
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req = '0;
            #1;
            if (c < 8) chk($sformatf("rr_gnt_%0d", c), 32'(gnt_a), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk($sformatf("rr_rsp_%0d", c), 32'(rsp_valid_a), 32'(1 << ((c - 2) % 4)));
                chk($sformatf("rr_data_%0d", c), 32'(rsp_data_a),
                    32'(romval(16'(16'h10 * (((c - 2) % 4) + 1)))));
            end
            tick();
        end

        // Requester-0 priority, then rotation among the rest without skipping 1
        rst_pulse();
        req = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("p0_gnt_%0d", c), 32'(gnt_b), 32'b0001);
            if (c == 2) chk("p0_rsp", 32'(rsp_valid_b), 32'b0001);
            tick();
        end
        req = 4'b1110;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("p0_rot_%0d", c), 32'(gnt_b), 32'(1 << ((c % 3) + 1)));
            tick();
        end
        req = '0;
        tick();
        tick();

        // Stall with a response in flight
        rst_pulse();
        req = 4'b1000;
        set_addr(3, 16'h0077);
        #1;
        chk("stall_pre_gnt", 32'(gnt_a), 32'b1000);
        tick();
        stall = 1'b1;
        req = 4'b0110;
        set_addr(1, 16'h0021);
        set_addr(2, 16'h0031);
        #1;
        chk("stall_gnt_0", 32'(gnt_a), 32'h0);
        chk("stall_busy", 32'(busy_a), 32'h1);
        tick();
        chk("stall_gnt_1", 32'(gnt_a), 32'h0);
        chk("stall_rsp_valid", 32'(rsp_valid_a), 32'b1000);
        chk("stall_rsp_data", 32'(rsp_data_a), 32'(romval(16'h0077)));
        tick();
        chk("stall_gnt_2", 32'(gnt_a), 32'h0);
        tick();
        stall = 1'b0;
        #1;
        chk("unstall_gnt_0", 32'(gnt_a), 32'b0010);
        tick();
        req = 4'b0100;
        #1;
        chk("unstall_gnt_1", 32'(gnt_a), 32'b0100);
        tick();
        req = '0;
        #1;
        chk("unstall_rsp_0", 32'(rsp_valid_a), 32'b0010);
        chk("unstall_data_0", 32'(rsp_data_a), 32'(romval(16'h0021)));
        tick();
        chk("unstall_rsp_1", 32'(rsp_valid_a), 32'b0100);
        chk("unstall_data_1", 32'(rsp_data_a), 32'(romval(16'h0031)));
        tick();

        // Reset one cycle after a grant flushes the pipeline
        req = 4'b0001;
        set_addr(0, 16'h0005);
        #1;
        chk("flush_gnt", 32'(gnt_a), 32'b0001);
        tick();
        req = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("flush_busy", 32'(busy_a), 32'h0);
        chk("flush_rsp_0", 32'(rsp_valid_a), 32'h0);
        chk("flush_rom_addr", 32'(rom_addr_a), 32'h0);
        tick();
        chk("flush_rsp_1", 32'(rsp_valid_a), 32'h0);
        rst_n = 1'b1;
        req = 4'b1001;
        set_addr(3, 16'h0333);
        #1;
        chk("flush_ptr_reset", 32'(gnt_a), 32'b0001);
        req = 4'b1000;
        #1;
        chk("flush_req3_gnt", 32'(gnt_a), 32'b1000);
        tick();
        req = '0;
        #1;
        chk("flush_req3_addr", 32'(rom_addr_a), 32'h0333);
        tick();
        chk("flush_req3_rsp", 32'(rsp_valid_a), 32'b1000);

        // Back-to-back grants to one requester with a new address every cycle
        rst_pulse();
        req = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) set_addr(2, 16'(c));
            if (c == 4) req = '0;
            #1;
            if (c < 4) chk($sformatf("b2b_gnt_%0d", c), 32'(gnt_a), 32'b0100);
            if (c >= 2) begin
                chk($sformatf("b2b_rsp_%0d", c), 32'(rsp_valid_a), 32'b0100);
                chk($sformatf("b2b_data_%0d", c), 32'(rsp_data_a), 32'(romval(16'(c - 2))));
            end
            tick();
        end
        chk("b2b_idle", 32'(rsp_valid_a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_rom_arbiter.md
Name: map_rom_arbiter

Overview:
- Shares one synchronous-read map ROM read port among NUM_REQ requesters, e.g. background renderer, player collision probe, enemy collision probes.
- Takes one request per cycle and drives the ROM address from a register.
- Returns the ROM word to the requester that issued it, with a one-hot response strobe, a fixed number of cycles later.
- Sits between the game logic/draw modules and the map ROM. Replaces giving each client its own dedicated ROM port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, ROM address width.
- DATA_W, 12, ROM word width (RGB 4:4:4).
- ROM_LAT, 1, ROM read latency in clocks from registered address to valid data.
- PRIO0, 0, 1 = requester 0 has strict priority; 0 = pure round-robin over all requesters.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NUM_REQ, request per requester; held with its address until granted.
- addr, input, NUM_REQ*ADDR_W, flat address bus; requester i uses bits [i*ADDR_W +: ADDR_W].
- stall, input, 1, 1 = issue no grants this cycle.
- gnt, output, NUM_REQ, combinational one-hot grant; the request is accepted at the clock edge where req[i]&gnt[i].
- rom_addr, output, ADDR_W, registered address to the ROM.
- rom_data, input, DATA_W, ROM read data.
- rsp_valid, output, NUM_REQ, one-hot; 1-cycle strobe marking the cycle rsp_data belongs to requester i.
- rsp_data, output, DATA_W, equals rom_data (pass-through).
- busy, output, 1, 1 while any accepted request has not yet been answered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rom_addr=0, rsp_valid=0, busy=0, rr_ptr=0, tag pipeline cleared.
  - gnt=0 while rst_n=0.
- Arbitration (combinational, every cycle):
  - If stall=1 or req==0: gnt=0.
  - If PRIO0=1 and req[0]=1: gnt=1<<0.
  - Otherwise gnt = the first set req bit searching upward from rr_ptr, modulo NUM_REQ. When PRIO0=1 and req[0]=0, bit 0 still takes part in the search.
  - At most one gnt bit is ever set; gnt[i] is never 1 when req[i]=0.
- Acceptance at the clock edge ending cycle T with grant to requester w:
  - rom_addr <= addr[w].
  - A tag (one-hot w, valid=1) enters a shift register of depth ROM_LAT+1.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - Exception: when PRIO0=1 and w=0, rr_ptr is unchanged, so the other requesters keep their place in the rotation.
- No grant in a cycle:
  - rom_addr holds its value; an invalid tag is shifted in; rr_ptr holds.
- Latency: the response for a request accepted in cycle T appears in cycle T+1+ROM_LAT.
  - In that cycle rsp_valid = tag one-hot and rsp_data = rom_data.
  - Default ROM_LAT=1 gives a response in T+2.
- Throughput: one accepted request per cycle, fully pipelined.
  - Back-to-back grants to the same requester are allowed when only it requests.
  - Responses return in grant order, one per cycle.
- Requester obligation: keep req and addr stable until the gnt edge. After that it may drop req or present a new address the very next cycle.
- Fairness:
  - PRIO0=0: any requester holding req is granted within NUM_REQ cycles that have stall=0.
  - PRIO0=1: requester 0 can starve the others; that is intentional for the renderer.
- stall=1 does not stop the pipeline. Requests already accepted still return their responses on time.
- busy = OR of the valid bits of all tag-pipeline stages, excluding the final output stage.
- Reset mid-operation flushes the tag pipeline: in-flight requests get no rsp_valid, and requesters must reissue them.
- An addr outside ROM depth is passed to the ROM unchanged; the arbiter does no range check.

Test Plan:
- Single request: req=0001, addr0=16'h0102 in cycle 0 (ROM preloaded rom[0x0102]=12'hABC) -> gnt=0001 in cycle 0; rom_addr=0x0102 from cycle 1; rsp_valid=0001 with rsp_data=12'hABC in cycle 2 only.
- All requesters continuous, PRIO0=0, addresses 0x10/0x20/0x30/0x40 -> gnt sequence 0001,0010,0100,1000,0001…; rsp_valid follows the same order delayed 2 cycles; rsp_data matches the words at 0x10/0x20/0x30/0x40.
- PRIO0=1, req=1111 held for 6 cycles -> gnt=0001 every cycle. Then drop req[0] -> gnt 0010,0100,1000,0010…, with no skip of requester 1.
- stall=1 for 3 cycles with req=0110 pending -> gnt=0 during stall; on release gnt=0010 then 0100. A response accepted just before stall still arrives on time.
- Reset asserted one cycle after a grant -> rsp_valid stays 0, busy=0, rr_ptr=0. After release, req=1000 alone is granted next cycle.
- Back-to-back same requester: req[2] held with addr changing every cycle (0,1,2,3) -> gnt[2]=1 each cycle; four consecutive rsp_valid=0100 with rom[0..3] in order.
